// File: rtl/mux2_arbiter.sv
// Round-robin arbiter for two requesters sharing a 2:1 mux, feeding a
// registered output word with a valid/ready handshake and a transfer counter.
module mux2_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req1,
  input  logic [WIDTH-1:0] in1,
  output logic             ack1,
  input  logic             req2,
  input  logic [WIDTH-1:0] in2,
  output logic             ack2,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt
);

  // Handshake: a word transfers on a rising edge where out_valid && out_ready;
  // out_valid, out and sel stay stable until then. Requests are sampled only
  // in IDLE. A requester holds req until its one-cycle ack.
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t state;
  logic   last;   // 0: requester 1 granted last, 1: requester 2

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      sel       <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      ack1      <= 1'b0;
      ack2      <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      ack1 <= 1'b0;
      ack2 <= 1'b0;
      case (state)
        IDLE: begin
          // On a tie, requester 1 wins only when requester 2 went last.
          if (req1 && (!req2 || last)) begin
            sel       <= 1'b0;
            out       <= in1;
            out_valid <= 1'b1;
            ack1      <= 1'b1;
            last      <= 1'b0;
            state     <= SEND;
          end else if (req2) begin
            sel       <= 1'b1;
            out       <= in2;
            out_valid <= 1'b1;
            ack2      <= 1'b1;
            last      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            xfer_cnt  <= xfer_cnt + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SEND);

endmodule

// File: tb/tb_mux2_arbiter.sv
// Bench for mux2_arbiter: directed phases with a queue of expected {sel,out}
// words that a monitor pops on each accepted transfer.
module tb_mux2_arbiter;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req1, req2, out_ready;
  logic [WIDTH-1:0] in1, in2;
  logic             ack1, ack2, sel, out_valid, busy;
  logic [WIDTH-1:0] out;
  logic [CNT_W-1:0] xfer_cnt;

  logic             s_ack1, s_ack2, s_sel, s_out_valid, s_busy;
  logic [WIDTH-1:0] s_out;
  logic [1:0]       s_xfer_cnt;

  logic [WIDTH:0] exp_q[$];
  logic [31:0]    exp_cnt;
  int             n_checks = 0;
  int             n_pass   = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  mux2_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req1(req1), .in1(in1), .ack1(ack1),
    .req2(req2), .in2(in2), .ack2(ack2),
    .sel(sel), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .xfer_cnt(xfer_cnt)
  );

  mux2_arbiter #(.WIDTH(WIDTH), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset),
    .req1(req1), .in1(in1), .ack1(s_ack1),
    .req2(req2), .in2(in2), .ack2(s_ack2),
    .sel(s_sel), .out(s_out), .out_valid(s_out_valid), .out_ready(out_ready),
    .busy(s_busy), .xfer_cnt(s_xfer_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // scoreboard monitor: outputs are stable at the falling edge
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      check("cnt", 32'(xfer_cnt), 32'(exp_cnt[CNT_W-1:0]));
      check("cnt_wrap", 32'(s_xfer_cnt), 32'(exp_cnt[1:0]));
      check("busy_valid", 32'(busy), 32'(out_valid));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("q_underflow", 32'd1, 32'd0);
        end else begin
          logic [WIDTH:0] e;
          e = exp_q.pop_front();
          check("word", 32'({sel, out}), 32'(e));
        end
        exp_cnt = exp_cnt + 1;
      end
    end
  end

  // driver tasks: drive and sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int idx, input int lat, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(ack1 || ack2) && n < 20);
    check({tag, "_ack"}, 32'({ack2, ack1}), (idx == 2) ? 32'd2 : 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req1 = 0; req2 = 0; in1 = '0; in2 = '0; out_ready = 0;
    exp_cnt = 0;
    repeat (2) tick();
    reset = 1'b0;

    // reset then idle
    repeat (5) begin
      tick();
      check("idle_out", 32'({out_valid, sel, out}), 32'd0);
      check("idle_ack", 32'({ack2, ack1, busy}), 32'd0);
    end

    // tie: both held, grants alternate 1,2,1,2
    in1 = 4'd8; in2 = 4'd7; req1 = 1; req2 = 1; out_ready = 1;
    for (int g = 0; g < 4; g++) begin
      int idx;
      idx = (g % 2 == 0) ? 1 : 2;
      exp_q.push_back((idx == 1) ? {1'b0, 4'd8} : {1'b1, 4'd7});
      wait_grant(idx, 1, "rr");
      if (g == 3) begin req1 = 0; req2 = 0; end
      tick();
      check("rr_ack_pulse", 32'({ack2, ack1}), 32'd0);
    end

    // back-pressure: in2 held, req1 waits
    out_ready = 0; req2 = 1; in2 = 4'd7;
    exp_q.push_back({1'b1, 4'd7});
    wait_grant(2, 1, "bp");
    req2 = 0; req1 = 1; in1 = 4'd8;
    repeat (4) begin
      tick();
      check("bp_hold", 32'({out_valid, sel, out}), 32'({1'b1, 1'b1, 4'd7}));
      check("bp_noack", 32'({ack2, ack1, busy}), 32'b001);
    end
    out_ready = 1;
    exp_q.push_back({1'b0, 4'd8});
    wait_grant(1, 2, "bp_next");
    req1 = 0;
    tick();

    // single request
    in1 = 4'd8; req1 = 1;
    exp_q.push_back({1'b0, 4'd8});
    wait_grant(1, 1, "single");
    check("single_out", 32'({out_valid, sel, out}), 32'({1'b1, 1'b0, 4'd8}));
    req1 = 0;
    tick();
    check("single_done", 32'({out_valid, busy, ack1}), 32'd0);
    tick();

    // counter wrap on the CNT_W=2 instance: 1,2,3,0,1
    do_reset(2);
    for (int t = 0; t < 5; t++) begin
      int idx;
      logic [WIDTH-1:0] d;
      idx = $urandom_range(1, 2);
      d = WIDTH'($urandom_range(0, 15));
      if (idx == 1) begin in1 = d; req1 = 1; end
      else begin in2 = d; req2 = 1; end
      exp_q.push_back({(idx == 2), d});
      wait_grant(idx, 1, "wrap");
      req1 = 0; req2 = 0;
      tick();
    end
    tick();
    check("wrap_final", 32'(s_xfer_cnt), 32'd1);
    check("wrap_final8", 32'(xfer_cnt), 32'd5);

    // asynchronous reset mid-SEND
    out_ready = 0; in1 = 4'd8; req1 = 1;
    exp_q.push_back({1'b0, 4'd8});
    wait_grant(1, 1, "rst");
    #2 reset = 1'b1; req1 = 0;
    #1;
    check("rst_out", 32'({out_valid, sel, out}), 32'd0);
    check("rst_ctl", 32'({ack2, ack1, busy}), 32'd0);
    check("rst_cnt", 32'(xfer_cnt), 32'd0);
    tick();
    reset = 1'b0;
    repeat (3) begin
      tick();
      check("rst_noack", 32'({ack1, out_valid}), 32'd0);
    end

    check("q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux2_arbiter.md
# mux2_arbiter

Two-requester arbiter and sequencer for the shared 4-bit 2-to-1 multiplexer datapath. It accepts request/acknowledge transactions from two sources, grants the shared path round-robin, and drives the mux select (`sel`, 0 = in1, 1 = in2). It registers the selected word into an output holding register with a valid/ready handshake toward the consumer, and keeps a wrap-around count of completed transfers.

## Interface
Parameters:
- `WIDTH`, default 4: data width of in1/in2/out.
- `CNT_W`, default 8: width of the transfer counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req1`  in  1  requester 1 has a word pending; held high until ack1.
- `in1`  in  WIDTH  requester 1 data; stable while req1 is high.
- `ack1`  out  1  one-cycle pulse: in1 captured.
- `req2`  in  1  requester 2 request, same rules as req1.
- `in2`  in  WIDTH  requester 2 data.
- `ack2`  out  1  one-cycle pulse: in2 captured.
- `sel`  out  1  registered mux select driven to the shared 2:1 mux; 0 = in1, 1 = in2.
- `out`  out  WIDTH  registered output word.
- `out_valid`  out  1  out holds an untaken word.
- `out_ready`  in  1  consumer accepts out on a cycle where out_valid && out_ready.
- `busy`  out  1  high whenever state is not IDLE.
- `xfer_cnt`  out  CNT_W  completed transfers, modulo 2^CNT_W.

## Operation
- States: IDLE, SEND.
- Round-robin pointer `last`: identity of the last requester granted. Reset value = 2, so in1 wins the first tie.
- IDLE, no request: stay in IDLE. sel holds its previous value. All ack outputs are 0.
- IDLE, exactly one request: grant that requester.
- IDLE, both requests: grant the requester that is not `last`.
- Grant at edge k:
  - sel <= granted index.
  - out <= granted input.
  - out_valid <= 1.
  - ack of the granted requester <= 1 for exactly one cycle.
  - last <= granted index.
  - state <= SEND.
- The non-granted requester is not acked. Its request stays pending.
- SEND:
  - out, sel and out_valid hold.
  - Requests are ignored, with no acks.
  - On an edge where out_ready = 1: out_valid <= 0, xfer_cnt <= xfer_cnt + 1 (wraps from 2^CNT_W−1 to 0), state <= IDLE.
- A requester may drop req only after its ack. Dropping req earlier is a protocol violation; behaviour is then undefined but the arbiter must not deadlock.
- `out` keeps its last value after out_valid falls. Consumers must qualify it with out_valid.

## Timing
- Reset values: out = 0, out_valid = 0, ack1 = ack2 = 0, sel = 0, busy = 0, xfer_cnt = 0, state = IDLE, last = 2.
- Reset asserted mid-SEND: all outputs return to reset values immediately (asynchronous). The pending word is discarded and not re-acked. xfer_cnt is not incremented.
- Request-to-data latency: req sampled high at edge k in IDLE gives out_valid, out, sel and ack visible after edge k (1 cycle).
- ack is high for exactly the cycle following the grant edge.
- Minimum transfer period is 2 cycles: grant edge, then accept edge. After accept the block is in IDLE, and the next grant occurs at the following edge at the earliest.
- Accept edge with both requests pending: the next grant goes to the requester not granted last. Continuous dual requests therefore alternate 1, 2, 1, 2, …
- out_ready while out_valid = 0 has no effect.
- busy = (state == SEND). It is combinational from state only, and is never driven by inputs.

## Test plan
- Reset then idle: hold reset 2 cycles and release with no requests for 5 cycles -> out = 0, out_valid = 0, sel = 0, acks = 0, xfer_cnt = 0 throughout.
- Single request: in1 = 4'd8, req1 = 1, out_ready = 1 -> after 1 edge: sel = 0, out = 4'b1000, out_valid = 1, ack1 pulse. After the next edge: out_valid = 0, xfer_cnt = 1.
- Tie and round-robin: in1 = 8, in2 = 7, both requests held, out_ready = 1, requests dropped one cycle after each ack and reasserted -> grants in order 1, 2, 1, 2 with out = 1000, 0111, 1000, 0111 and sel = 0, 1, 0, 1.
- Back-pressure: grant in2 = 7 with out_ready = 0 for 4 cycles, req1 high meanwhile -> out = 0111 and sel = 1 held, no ack1, busy = 1. Raise out_ready -> accept, then in1 granted on the next edge.
- Counter wrap: CNT_W = 2, perform 5 transfers -> xfer_cnt sequence 1, 2, 3, 0, 1.
- Reset mid-SEND: grant in1 = 8 with out_ready = 0, then pulse reset asynchronously mid-cycle -> out_valid = 0, out = 0, xfer_cnt unchanged at 0, no second ack1 until req1 is re-arbitrated.
